ahb_lite_master_arbiter: RTL and testbench
==========================================

Name: ahb_lite_master_arbiter

Overview:
- Two-requester AHB-Lite master front end for the system bus that carries the GPIO/LED slave.
- Arbitrates user-side requests (CPU port 0, debug/user port 1) round-robin.
- Sequences each granted request as one single-beat, word-sized AHB-Lite transfer, honouring HREADY wait states.
- Returns read data and completion to the granted requester.

Parameters:
- AW, 32, address width
- DW, 32, data width

Ports:
- Clk  in  1  system clock, all state on rising edge
- Rst  in  1  asynchronous, active-high reset
- req0  in  1  port 0 request, level, held until done0
- wr0  in  1  port 0 write (1) / read (0)
- addr0  in  AW  port 0 byte address
- wdata0  in  DW  port 0 write data
- req1, wr1, addr1, wdata1  in  1/1/AW/DW  port 1 equivalents
- done0  out  1  one-cycle completion pulse, port 0
- done1  out  1  one-cycle completion pulse, port 1
- rdata  out  DW  read data, valid while done0 or done1 is high
- err  out  1  HRESP error flag, valid with done pulse
- HADDR  out  AW  AHB address
- HWRITE  out  1  AHB write
- HTRANS  out  2  AHB transfer type; only IDLE (00) and NONSEQ (10) used
- HSIZE  out  3  constant 3'b010 (word)
- HWDATA  out  DW  AHB write data
- HRDATA  in  DW  AHB read data
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB response; 1 = error

Behaviour:
- Reset values, applied asynchronously while Rst=1:
  - HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, rdata=0.
  - done0=done1=0, err=0.
  - state=IDLE, last_grant=1, so port 0 wins the first tie.
  - Reset asserted mid-transfer aborts it immediately; no done pulse is ever generated for the aborted request.
- All outputs are registered.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - If any req is high, grant and latch that port's wr/addr/wdata and record grant.
  - Next state ADDR with HTRANS=NONSEQ, HADDR/HWRITE from the latch.
  - If no req, stay in IDLE with HTRANS=IDLE.
- Arbitration:
  - Single requester: that requester wins.
  - Both requesting: the port not equal to last_grant wins.
  - last_grant updates on grant.
- ADDR:
  - If HREADY=1: next DATA, HTRANS=IDLE, HWDATA=latched wdata.
  - If HREADY=0: hold all address-phase outputs unchanged.
- DATA:
  - If HREADY=1: capture HRDATA into rdata when the transfer is a read; for a write, rdata holds its previous value.
  - Also on HREADY=1: err=HRESP; pulse done of the granted port; next state RESP.
  - If HREADY=0: hold HWDATA and wait, with no timeout.
- RESP:
  - The done pulse is high for exactly this one cycle; done low and next IDLE.
  - No grant is issued in RESP, so a requester that drops req in the cycle done is high is not re-served.
- A req still high in IDLE after RESP is treated as a new request.
- Zero-wait latency: req sampled at edge N gives NONSEQ after edge N, done high after edge N+2, IDLE after edge N+3. Back-to-back grants therefore come every 4 cycles.
- Each wait state in ADDR or DATA adds exactly one cycle.
- Changes to a requester's addr/wdata after its grant have no effect on the transfer in flight.
- A request arriving while busy waits; no request is dropped.

Test Plan:
- Reset with Rst=1 at t=0, released at t=12ns, HREADY=1 -> all outputs 0, HTRANS=00 until the first req.
- Single read: port 0 read, addr0=0x0, HRDATA=0x0000_00A5 -> HTRANS=10/HADDR=0 one cycle, then done0 with rdata=0xA5, err=0, 3 cycles after req.
- Single write: port 1 write, addr1=0x0, wdata1=0x0A -> HWRITE=1 in address phase, HWDATA=0x0A in data phase, done1 pulse, LED slave shows 0x0A.
- Contention: req0 and req1 both high from reset, held until done -> order port0, port1, port0, port1; grants 4 cycles apart.
- Wait states: HREADY low 2 cycles in ADDR and 3 in DATA -> outputs held stable, done delayed by 5 cycles, exactly one done pulse.
- Error and reset abort:
  - HRESP=1 with HREADY=1 in DATA -> err=1 with the done pulse.
  - Rst pulse during DATA -> HTRANS=00 immediately, no done, and the next req is served normally.

Source files
------------

// File: rtl/ahb_lite_master_arbiter.sv
// Two-port round-robin front end that turns each granted request into a single
// word-sized AHB-Lite transfer and returns completion/read data to the requester.
module ahb_lite_master_arbiter #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          req0,
   input  logic          wr0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          wr1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          done0,
   output logic          done1,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic [AW-1:0] HADDR,
   output logic          HWRITE,
   output logic [1:0]    HTRANS,
   output logic [2:0]    HSIZE,
   output logic [DW-1:0] HWDATA,
   input  logic [DW-1:0] HRDATA,
   input  logic          HREADY,
   input  logic          HRESP
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   localparam logic [1:0] TRANS_IDLE   = 2'b00;
   localparam logic [1:0] TRANS_NONSEQ = 2'b10;

   state_t        state;
   state_t        next_state;
   logic          last_grant;
   logic          gnt;
   logic          pick;
   logic [DW-1:0] wdata_q;

   assign HSIZE = 3'b010;

   // On a tie the port that was not served last wins.
   always_comb begin
      pick = (req0 && req1) ? ~last_grant : req1;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (req0 || req1) next_state = ADDR;
         ADDR:    if (HREADY)       next_state = DATA;
         DATA:    if (HREADY)       next_state = RESP;
         RESP:                      next_state = IDLE;
         default:                   next_state = IDLE;
      endcase
   end

   // Everything the requesters and the bus see is registered; the request is
   // latched at grant so later changes on the user side cannot disturb it.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         HTRANS     <= TRANS_IDLE;
         HADDR      <= '0;
         HWRITE     <= 1'b0;
         HWDATA     <= '0;
         rdata      <= '0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         err        <= 1'b0;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         wdata_q    <= '0;
      end else begin
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gnt        <= pick;
                  last_grant <= pick;
                  HTRANS     <= TRANS_NONSEQ;
                  HADDR      <= pick ? addr1  : addr0;
                  HWRITE     <= pick ? wr1    : wr0;
                  wdata_q    <= pick ? wdata1 : wdata0;
               end else begin
                  HTRANS <= TRANS_IDLE;
               end
            end
            ADDR: begin
               if (HREADY) begin
                  HTRANS <= TRANS_IDLE;
                  HWDATA <= wdata_q;
               end
            end
            DATA: begin
               if (HREADY) begin
                  if (!HWRITE) rdata <= HRDATA;
                  err   <= HRESP;
                  done0 <= ~gnt;
                  done1 <= gnt;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Directed bench for ahb_lite_master_arbiter with a one-register LED slave model
// at address 0 and hand-computed expectations.
module tb_ahb_lite_master_arbiter;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
   logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
   logic        done0, done1, err, HWRITE;
   logic [31:0] rdata, HADDR, HWDATA;
   logic [31:0] HRDATA = '0;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HREADY = 1'b1;
   logic        HRESP = 1'b0;

   int passed = 0;
   int total = 0;
   int cycles;
   int order [4] = '{0, 1, 0, 1};

   logic [31:0] led = '0;
   logic        pendWr = 1'b0;

   ahb_lite_master_arbiter #(.AW(32), .DW(32)) dut (
      .Clk(Clk), .Rst(Rst),
      .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
      .done0(done0), .done1(done1), .rdata(rdata), .err(err),
      .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 Clk = ~Clk;

   // LED slave: a write address phase to 0 updates the register at the end of its data phase.
   always @(posedge Clk) begin
      if (HREADY) begin
         if (pendWr) led <= HWDATA;
         pendWr <= (HTRANS == 2'b10) && HWRITE && (HADDR == 32'h0);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                                input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
      req0 = r0; wr0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; wr1 = w1; addr1 = a1; wdata1 = d1;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic waitDone(output int cyc);
      cyc = 0;
      do begin
         @(negedge Clk);
         cyc++;
      end while (!(done0 || done1) && cyc < 12);
   endtask

   initial begin
      // Reset state, during and after release
      step(1);
      checkOutput("rst_htrans", HTRANS, 2'b00);
      checkOutput("rst_haddr", HADDR, 32'h0);
      checkOutput("rst_done", {done0, done1, err, HWRITE}, 4'b0000);
      checkOutput("rst_hsize", HSIZE, 3'b010);
      #2 Rst = 1'b0;
      step(1);
      checkOutput("idle_htrans", HTRANS, 2'b00);
      checkOutput("idle_rdata", rdata, 32'h0);
      checkOutput("idle_hwdata", HWDATA, 32'h0);

      // Single read from port 0
      applyStimulus(1, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
      HRDATA = 32'h0000_00A5;
      step(1);
      checkOutput("rd_htrans_a", HTRANS, 2'b10);
      checkOutput("rd_haddr", HADDR, 32'h0);
      checkOutput("rd_hwrite", HWRITE, 1'b0);
      step(1);
      checkOutput("rd_htrans_d", HTRANS, 2'b00);
      checkOutput("rd_done_early", done0, 1'b0);
      step(1);
      checkOutput("rd_done0", {done0, done1}, 2'b10);
      checkOutput("rd_rdata", rdata, 32'hA5);
      checkOutput("rd_err", err, 1'b0);
      req0 = 1'b0;
      step(1);
      checkOutput("rd_done_off", done0, 1'b0);
      step(1);
      checkOutput("rd_no_reserve", HTRANS, 2'b00);

      // Single write from port 1; wdata changes after grant must not leak through
      applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'h0, 32'h0A);
      step(1);
      checkOutput("wr_htrans", HTRANS, 2'b10);
      checkOutput("wr_hwrite", HWRITE, 1'b1);
      wdata1 = 32'hFF;
      step(1);
      checkOutput("wr_hwdata", HWDATA, 32'h0A);
      step(1);
      checkOutput("wr_done1", {done0, done1}, 2'b01);
      checkOutput("wr_rdata_hold", rdata, 32'hA5);
      req1 = 1'b0;
      step(1);
      checkOutput("wr_led", led, 32'h0A);

      // Contention from reset: port 0 first, then strict alternation every 4 cycles
      Rst = 1'b1;
      step(1);
      checkOutput("rst2_htrans", HTRANS, 2'b00);
      applyStimulus(1, 0, 32'h20, 32'h0, 1, 0, 32'h24, 32'h0);
      Rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         waitDone(cycles);
         checkOutput("cont_port", {done0, done1}, order[k] ? 2'b01 : 2'b10);
         checkOutput("cont_gap", cycles, (k == 0) ? 3 : 4);
      end
      req0 = 1'b0;
      req1 = 1'b0;
      step(2);
      checkOutput("cont_idle", HTRANS, 2'b00);

      // Wait states: two in the address phase, three in the data phase
      applyStimulus(1, 0, 32'h4, 32'h0, 0, 0, 32'h0, 32'h0);
      HRDATA = 32'h1234;
      step(1);
      checkOutput("ws_htrans", HTRANS, 2'b10);
      HREADY = 1'b0;
      step(1);
      checkOutput("ws_hold_trans", HTRANS, 2'b10);
      checkOutput("ws_hold_addr", HADDR, 32'h4);
      step(1);
      checkOutput("ws_hold_trans2", HTRANS, 2'b10);
      HREADY = 1'b1;
      step(1);
      checkOutput("ws_data_trans", HTRANS, 2'b00);
      HREADY = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1);
         checkOutput("ws_no_done", done0, 1'b0);
      end
      HREADY = 1'b1;
      step(1);
      checkOutput("ws_done0", done0, 1'b1);
      checkOutput("ws_rdata", rdata, 32'h1234);
      req0 = 1'b0;
      step(1);
      checkOutput("ws_single_pulse", done0, 1'b0);
      step(1);

      // Error response
      applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h8, 32'h0);
      HRESP = 1'b1;
      waitDone(cycles);
      checkOutput("err_lat", cycles, 3);
      checkOutput("err_done1", done1, 1'b1);
      checkOutput("err_flag", err, 1'b1);
      req1 = 1'b0;
      HRESP = 1'b0;
      step(2);

      // Reset during the data phase aborts without a done pulse
      applyStimulus(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
      step(1);
      checkOutput("ab_haddr", HADDR, 32'h10);
      step(1);
      HREADY = 1'b0;
      #2 Rst = 1'b1;
      #1;
      checkOutput("ab_async_haddr", HADDR, 32'h0);
      checkOutput("ab_async_trans", HTRANS, 2'b00);
      checkOutput("ab_async_err", err, 1'b0);
      req0 = 1'b0;
      step(1);
      Rst = 1'b0;
      HREADY = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step(1);
         checkOutput("ab_no_done", {done0, done1}, 2'b00);
      end
      applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'h0, 32'h3C);
      waitDone(cycles);
      checkOutput("ab_next_lat", cycles, 3);
      checkOutput("ab_next_done1", {done0, done1}, 2'b01);
      req1 = 1'b0;
      step(1);
      checkOutput("ab_next_led", led, 32'h3C);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
